seg7_display_driver: RTL and testbench

Drives the four-digit, common-anode seven-segment display from the calculator's 16-bit accumulator value (the same word the calculator presents on its LEDs). It sits between the calculator core and the board pins and is the display-side consumer of the calculator result. It captures the value on a load strobe, time-multiplexes the four hex digits with a prescaled refresh counter, and optionally suppresses leading zeros.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/hex_to_seg7.sv | 32 +++
 rtl/seg7_display_driver.sv | 83 ++++++++
 tb/tb_seg7_display_driver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator display constants: active-low seven-segment patterns {g,f,e,d,c,b,a}
// for every hex digit, plus the all-off values for segments and anodes.
package calc_pkg;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
   import calc_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg7_display_driver.sv
// Four-digit common-anode display driver: captures the calculator value on load,
// scans the hex digits with a prescaled refresh counter, optionally blanks leading zeros.
module seg7_display_driver
   import calc_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter bit LZ_SUPPRESS = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        blank,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int PCNT_W = $clog2(REFRESH_DIV);
   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(REFRESH_DIV - 1);

   logic [15:0]       shown;
   logic [PCNT_W-1:0] pcnt;
   logic [1:0]        dsel;
   logic              tick;
   logic [3:0]        nibble;
   logic [6:0]        nibble_seg;
   logic              suppressed;
   logic [3:0]        an_next;
   logic [6:0]        seg_next;

   assign tick   = (pcnt == PCNT_MAX);
   assign nibble = shown[{dsel, 2'b00} +: 4];
   assign dp     = 1'b1;

   hex_to_seg7 u_dec (
      .nibble (nibble),
      .seg    (nibble_seg)
   );

   // A digit is a leading zero when it and every more significant nibble are zero.
   always_comb begin
      suppressed = 1'b0;
      case (dsel)
         2'd1:    suppressed = (shown[15:4] == 12'h000);
         2'd2:    suppressed = (shown[15:8] == 8'h00);
         2'd3:    suppressed = (shown[15:12] == 4'h0);
         default: suppressed = 1'b0;
      endcase
      suppressed = suppressed & LZ_SUPPRESS;
   end

   always_comb begin
      an_next  = AN_OFF;
      seg_next = SEG_OFF;
      if (!blank && !suppressed) begin
         an_next  = ~(4'b0001 << dsel);
         seg_next = nibble_seg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shown <= 16'h0000;
         pcnt  <= '0;
         dsel  <= 2'd0;
         an    <= AN_OFF;
         seg   <= SEG_OFF;
      end else begin
         if (load)
            shown <= value;
         if (tick) begin
            pcnt <= '0;
            dsel <= dsel + 2'd1;
         end else begin
            pcnt <= pcnt + PCNT_W'(1);
         end
         an  <= an_next;
         seg <= seg_next;
      end
   end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Bench for seg7_display_driver: two instances (leading-zero suppression on and off)
// checked every cycle against a cycle-count model, plus table vectors and corner sequences.
module tb_seg7_display_driver;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] value = 16'h0000;
   logic        load = 1'b0;
   logic        blank = 1'b0;
   logic [3:0]  an1, an0;
   logic [6:0]  seg1, seg0;
   logic        dp1, dp0;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_shown;
   int          m_n;
   logic [6:0]  hexmap [16];

   typedef struct {
      logic [15:0] val;
      logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
      logic [3:0]  lit;   // digits lit with suppression enabled
   } vec_t;

   vec_t tbl [5];

   always #5 clk = ~clk;

   seg7_display_driver #(.REFRESH_DIV(DIV), .LZ_SUPPRESS(1'b1)) dut_lz (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank(blank),
      .an(an1), .seg(seg1), .dp(dp1)
   );

   seg7_display_driver #(.REFRESH_DIV(DIV), .LZ_SUPPRESS(1'b0)) dut_nolz (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank(blank),
      .an(an0), .seg(seg0), .dp(dp0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected display for a given stored value, active digit and blank level.
   function automatic void model(input bit lz, input logic [15:0] sh, input int d,
                                 input logic bl, output logic [3:0] ea, output logic [6:0] es);
      logic [3:0] nb;
      bit         supp;
      nb   = 4'(sh >> (4 * d));
      supp = lz && (d >= 1) && ((sh >> (4 * d)) == 16'h0000);
      if (bl || supp) begin
         ea = 4'hF;
         es = 7'h7F;
      end else begin
         ea = 4'hF & ~(4'd1 << d);
         es = hexmap[nb];
      end
   endfunction

   task automatic step();
      logic [3:0] ea1, ea0;
      logic [6:0] es1, es0;
      model(1'b1, m_shown, (m_n / DIV) % 4, blank, ea1, es1);
      model(1'b0, m_shown, (m_n / DIV) % 4, blank, ea0, es0);
      @(posedge clk);
      if (load) m_shown = value;
      m_n++;
      #1;
      chk("an_lz",    32'(an1),  32'(ea1));
      chk("seg_lz",   32'(seg1), 32'(es1));
      chk("an_nolz",  32'(an0),  32'(ea0));
      chk("seg_nolz", 32'(seg0), 32'(es0));
      chk("dp",       32'({dp1, dp0}), 32'(2'b11));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_an",  32'({an1, an0}),   32'(8'hFF));
      chk("rst_seg", 32'({seg1, seg0}), 32'(14'h3FFF));
      chk("rst_dp",  32'({dp1, dp0}),   32'(2'b11));
      m_shown = 16'h0000;
      m_n     = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int k;
      hexmap = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      tbl[0] = '{16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
      tbl[1] = '{16'h00A0, {7'b1000000, 7'b1000000, 7'b0001000, 7'b1000000}, 4'b0011};
      tbl[2] = '{16'h0000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0001};
      tbl[3] = '{16'h8F0A, {7'b0000000, 7'b0001110, 7'b1000000, 7'b0001000}, 4'b1111};
      tbl[4] = '{16'h0100, {7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000}, 4'b0111};

      // Table vectors: load on the first edge, then one full frame plus wrap.
      for (int v = 0; v < 5; v++) begin
         value = tbl[v].val;
         load  = 1'b1;
         do_reset();
         for (int e = 1; e <= 17; e++) begin
            step();
            if (e == 1) begin
               load = 1'b0;
               chk("first_edge", 32'({an1, seg1}), 32'({4'b1110, 7'b1000000}));
            end
            if (e % 4 == 0) begin
               k = e / 4 - 1;
               chk("tbl_an_nolz",  32'(an0),  32'(4'hF & ~(4'd1 << k)));
               chk("tbl_seg_nolz", 32'(seg0), 32'(tbl[v].segs[7*k +: 7]));
               if (tbl[v].lit[k]) begin
                  chk("tbl_an_lz",  32'(an1),  32'(4'hF & ~(4'd1 << k)));
                  chk("tbl_seg_lz", 32'(seg1), 32'(tbl[v].segs[7*k +: 7]));
               end else begin
                  chk("tbl_an_lz_off",  32'(an1),  32'(4'hF));
                  chk("tbl_seg_lz_off", 32'(seg1), 32'(7'h7F));
               end
            end
            if (e == 17)
               chk("tbl_wrap_an", 32'(an0), 32'(4'b1110));
         end
      end

      // Blank while digit 1 is active; the scan keeps running underneath.
      value = 16'h1234;
      load  = 1'b1;
      do_reset();
      step();
      load = 1'b0;
      for (int e = 2; e <= 5; e++) step();
      chk("blank_pre_an", 32'(an1), 32'(4'b1101));
      blank = 1'b1;
      step();
      chk("blank_an", 32'(an1), 32'(4'hF));
      for (int e = 7; e <= 10; e++) step();
      blank = 1'b0;
      step();
      chk("unblank_an",  32'(an1),  32'(4'b1011));
      chk("unblank_seg", 32'(seg1), 32'(7'b0100100));

      // Load while digit 0 is showing.
      load = 1'b0;
      do_reset();
      step();
      value = 16'h000F;
      load  = 1'b1;
      step();
      load = 1'b0;
      step();
      chk("load_disp_an",  32'(an1),  32'(4'b1110));
      chk("load_disp_seg", 32'(seg1), 32'(7'b0001110));

      // Load coinciding with the digit 0 -> 1 tick.
      value = 16'hFFFF;
      load  = 1'b1;
      do_reset();
      step();
      load = 1'b0;
      step();
      step();
      value = 16'h8888;
      load  = 1'b1;
      step();
      load = 1'b0;
      step();
      chk("load_tick_an",  32'(an1),  32'(4'b1101));
      chk("load_tick_seg", 32'(seg1), 32'(7'b0000000));

      // Randomized traffic with an asynchronous reset in the middle of a scan.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         value = 16'($urandom);
         if ($urandom_range(0, 2) == 0)
            value = value & 16'h00FF;
         load  = ($urandom_range(0, 3) == 0);
         blank = ($urandom_range(0, 7) == 0);
         step();
         if (i == 201) begin
            load  = 1'b0;
            blank = 1'b0;
            do_reset();
            step();
            chk("post_rst_an",  32'(an1),  32'(4'b1110));
            chk("post_rst_seg", 32'(seg1), 32'(7'b1000000));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
